// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops words from a synchronous FIFO read port.
// Back-to-back frames are chained straight from the last stop cycle into the next start bit.
module fifo_uart_tx #(
  parameter int B            = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         empty,
  input  logic [B-1:0] r_data,
  output logic         rd,
  output logic         tx,
  output logic         busy
);

  // state | meaning
  // IDLE  | line high, waiting for en=1 and a non-empty FIFO
  // START | start bit (tx=0) for CLKS_PER_BIT cycles
  // DATA  | B data bits, LSB first, each CLKS_PER_BIT cycles
  // STOP  | stop bit (tx=1); last cycle may chain into the next frame
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (B > 1) ? $clog2(B) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(B - 1);

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [IW-1:0]  idx, idx_nx;
  logic [B-1:0]   sh, sh_nx, sh_shift;
  logic           tx_nx, rd_nx, load, cnt_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx    <= 1'b1;
      rd    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      sh    <= sh_nx;
      tx    <= tx_nx;
      rd    <= rd_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    sh_nx    = sh;
    tx_nx    = tx;
    rd_nx    = 1'b0;
    load     = 1'b0;
    cnt_last = (cnt == CNT_LAST);
    sh_shift = sh >> 1;
    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        load  = en & ~empty;
      end
      START: begin
        if (cnt_last) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          tx_nx    = sh[0];
          state_nx = DATA;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_nx = '0;
          if (idx == IDX_LAST) begin
            tx_nx    = 1'b1;
            state_nx = STOP;
          end else begin
            sh_nx  = sh_shift;
            tx_nx  = sh_shift[0];
            idx_nx = idx + IW'(1);
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_nx   = '0;
          state_nx = IDLE;
          load     = en & ~empty;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    // Shared frame-start path from IDLE and from the final stop cycle.
    if (load) begin
      sh_nx    = r_data;
      rd_nx    = 1'b1;
      tx_nx    = 1'b0;
      cnt_nx   = '0;
      state_nx = START;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a behavioural 4-deep FIFO feeds the DUT, a line decoder
// recovers 8N1 frames sample-by-sample and checks them against the written byte order.
module tb_fifo_uart_tx;
  localparam int B     = 8;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = (B + 2) * CPB;

  logic         clk = 1'b0;
  logic         rst, en, wr;
  logic         empty = 1'b1;
  logic         full = 1'b0;
  logic [B-1:0] r_data = '0;
  logic [B-1:0] w_data;
  logic         rd, tx, busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int underflow = 0;
  int rd_log[$];
  logic [B-1:0] fq[$];
  logic [B-1:0] exp_q[$];

  always #10 clk = ~clk;

  fifo_uart_tx #(.B(B), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .en(en), .empty(empty), .r_data(r_data),
    .rd(rd), .tx(tx), .busy(busy)
  );

  // Synchronous FIFO: pop on rd, push on wr, flags registered at the same edge.
  always @(posedge clk) begin
    cyc++;
    if (rd) begin
      if (fq.size() == 0) underflow++;
      else fq.delete(0);
    end
    if (wr && fq.size() < DEPTH) fq.push_back(w_data);
    empty  <= (fq.size() == 0);
    full   <= (fq.size() == DEPTH);
    r_data <= (fq.size() > 0) ? fq[0] : '0;
  end

  always @(negedge clk) begin
    if (rd) rd_log.push_back(cyc);
    if (busy) busy_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: sim time limit reached, want finish");
    $fatal(1);
  end

  task automatic write_byte(input logic [B-1:0] d);
    @(negedge clk);
    wr = 1'b1;
    w_data = d;
    exp_q.push_back(d);
    @(negedge clk);
    wr = 1'b0;
  endtask

  // Decodes one frame from negedge samples; first low sample must appear within max_wait samples.
  task automatic recv_frame(input int max_wait, output logic [B-1:0] b, output bit ok,
                            output bit got, output int start_cyc);
    int w;
    logic bitv;
    w = 0; b = '0; ok = 1'b1; got = 1'b0; start_cyc = -1;
    @(negedge clk);
    while (tx !== 1'b0 && w < max_wait - 1) begin
      w++;
      @(negedge clk);
    end
    if (tx !== 1'b0) return;
    got = 1'b1;
    start_cyc = cyc;
    for (int s = 1; s < CPB; s++) begin @(negedge clk); if (tx !== 1'b0) ok = 1'b0; end
    for (int i = 0; i < B; i++) begin
      @(negedge clk);
      bitv = tx;
      b[i] = bitv;
      for (int s = 1; s < CPB; s++) begin @(negedge clk); if (tx !== bitv) ok = 1'b0; end
    end
    for (int s = 0; s < CPB; s++) begin @(negedge clk); if (tx !== 1'b1) ok = 1'b0; end
  endtask

  task automatic idle_watch(input int n, output int rd_seen, output int tx_low, output int busy_seen);
    rd_seen = 0; tx_low = 0; busy_seen = 0;
    repeat (n) begin
      @(negedge clk); #1;
      if (rd !== 1'b0) rd_seen++;
      if (tx !== 1'b1) tx_low++;
      if (busy !== 1'b0) busy_seen++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b0; wr = 1'b0; w_data = '0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    total++; if (rd !== 1'b0) begin bad++; $display("FAIL reset_rd: got %b want 0", rd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    logic [B-1:0] b; bit ok, got; int sc;
    rd_log.delete(); exp_q.delete();
    en = 1'b1;
    write_byte(8'hDA);
    busy_cnt = 0;
    recv_frame(20, b, ok, got, sc);
    total++; if (!got) begin bad++; $display("FAIL single_start: no start bit seen"); end
    total++; if (!ok) begin bad++; $display("FAIL single_shape: frame bits not held %0d cycles", CPB); end
    total++; if (b !== 8'hDA) begin bad++; $display("FAIL single_data: got %h want da", b); end
    @(negedge clk); #1;
    total++; if (busy_cnt !== FRAME) begin bad++; $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, FRAME); end
    total++; if (busy !== 1'b0 || tx !== 1'b1) begin bad++; $display("FAIL single_after: busy=%b tx=%b want 0 1", busy, tx); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_empty: got %b want 1", empty); end
    total++; if (rd_log.size() !== 1) begin bad++; $display("FAIL single_rd_count: got %0d want 1", rd_log.size()); end
    else begin
      total++; if (rd_log[0] !== sc) begin bad++; $display("FAIL single_rd_align: rd cycle %0d want %0d", rd_log[0], sc); end
    end
  endtask

  // Preload n bytes with en low, then expect them back-to-back with rd exactly one frame apart.
  task automatic run_burst(input string name, input int n);
    logic [B-1:0] b, want; bit ok, got; int sc;
    int starts[$];
    rd_log.delete();
    en = 1'b1;
    for (int f = 0; f < n; f++) begin
      recv_frame((f == 0) ? 20 : 1, b, ok, got, sc);
      want = exp_q.pop_front();
      total++; if (!got || !ok) begin bad++; $display("FAIL %s_frame%0d: got=%0b shape=%0b (gap or bad timing)", name, f, got, ok); end
      total++; if (b !== want) begin bad++; $display("FAIL %s_data%0d: got %h want %h", name, f, b, want); end
      starts.push_back(sc);
    end
    @(negedge clk); #1;
    total++; if (rd_log.size() !== n) begin bad++; $display("FAIL %s_rd_count: got %0d want %0d", name, rd_log.size(), n); end
    else begin
      for (int f = 1; f < n; f++) begin
        total++; if (rd_log[f] - rd_log[f-1] !== FRAME) begin bad++; $display("FAIL %s_rd_gap%0d: got %0d want %0d", name, f, rd_log[f] - rd_log[f-1], FRAME); end
      end
      total++; if (rd_log[0] !== starts[0]) begin bad++; $display("FAIL %s_rd_align: got %0d want %0d", name, rd_log[0], starts[0]); end
    end
    total++; if (empty !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL %s_end: empty=%b busy=%b want 1 0", name, empty, busy); end
  endtask

  task automatic test_burst;
    exp_q.delete();
    en = 1'b0;
    write_byte(8'hDA); write_byte(8'h31); write_byte(8'h0E); write_byte(8'hE1);
    run_burst("burst", 4);
  endtask

  task automatic test_empty;
    int r, t, bz;
    rd_log.delete();
    en = 1'b1;
    idle_watch(200, r, t, bz);
    total++; if (r !== 0) begin bad++; $display("FAIL empty_rd: got %0d rd cycles want 0", r); end
    total++; if (t !== 0) begin bad++; $display("FAIL empty_tx: got %0d low cycles want 0", t); end
    total++; if (bz !== 0) begin bad++; $display("FAIL empty_busy: got %0d busy cycles want 0", bz); end
  endtask

  task automatic test_enable;
    logic [B-1:0] b; bit ok, got; int sc, r, t, bz;
    exp_q.delete(); rd_log.delete();
    en = 1'b0;
    write_byte(8'h31); write_byte(8'h0E);
    en = 1'b1;
    fork
      recv_frame(20, b, ok, got, sc);
      begin repeat (10) @(negedge clk); en = 1'b0; end
    join
    total++; if (!got || !ok || b !== 8'h31) begin bad++; $display("FAIL enable_first: got=%0b shape=%0b data %h want 31", got, ok, b); end
    idle_watch(100, r, t, bz);
    total++; if (rd_log.size() !== 1 || r !== 0) begin bad++; $display("FAIL enable_hold: rd pulses %0d want 1", rd_log.size()); end
    total++; if (t !== 0 || bz !== 0) begin bad++; $display("FAIL enable_idle: tx low %0d busy %0d want 0 0", t, bz); end
    en = 1'b1;
    recv_frame(20, b, ok, got, sc);
    total++; if (!got || !ok || b !== 8'h0E) begin bad++; $display("FAIL enable_second: got=%0b shape=%0b data %h want 0e", got, ok, b); end
    total++; if (rd_log.size() !== 2) begin bad++; $display("FAIL enable_rd_count: got %0d want 2", rd_log.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [B-1:0] b; bit ok, got; int sc, w, r, t, bz;
    exp_q.delete(); rd_log.delete();
    en = 1'b0;
    write_byte(8'hE1); write_byte(8'h5A);
    en = 1'b1;
    w = 0;
    @(negedge clk);
    while (tx !== 1'b0 && w < 20) begin w++; @(negedge clk); end
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL rstmid_start: tx %b want 0 within 20 cycles", tx); end
    repeat (14) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    total++; if (tx !== 1'b1 || rd !== 1'b0) begin bad++; $display("FAIL rstmid_async: tx=%b rd=%b want 1 0", tx, rd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
    recv_frame(20, b, ok, got, sc);
    total++; if (!got || !ok || b !== 8'h5A) begin bad++; $display("FAIL rstmid_next: got=%0b shape=%0b data %h want 5a", got, ok, b); end
    idle_watch(100, r, t, bz);
    total++; if (t !== 0 || r !== 0 || rd_log.size() !== 2) begin bad++; $display("FAIL rstmid_no_resend: tx low %0d rd pulses %0d want 0 2", t, rd_log.size()); end
    exp_q.delete();
  endtask

  task automatic test_full;
    logic f1;
    exp_q.delete();
    en = 1'b0;
    for (int i = 0; i < DEPTH; i++) write_byte(B'(i));
    #1;
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_set: got %b want 1", full); end
    fork
      run_burst("wrap", DEPTH);
      begin
        f1 = 1'b1;
        for (int k = 0; k < 60 && rd !== 1'b1; k++) @(negedge clk);
        @(negedge clk); #1;
        f1 = full;
      end
    join
    total++; if (f1 !== 1'b0) begin bad++; $display("FAIL full_clear: got %b want 0 after first pop", f1); end
  endtask

  task automatic test_random;
    int n;
    for (int round = 0; round < 3; round++) begin
      exp_q.delete();
      en = 1'b0;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) write_byte(B'($urandom));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_burst("random", n);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_empty;
    test_enable;
    test_reset_mid;
    test_full;
    test_random;
    total++; if (underflow !== 0) begin bad++; $display("FAIL underflow: rd while empty %0d times want 0", underflow); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
